div_unit: RTL and testbench

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the sequential counterpart of the single-cycle ALU in the execute stage. It accepts two operands and an op code through a start/valid handshake and produces one result after a fixed-latency radix-2 restoring loop. Divide-by-zero and signed overflow take a short path. The pipeline holds execute while `busy_o` is high.

---
 rtl/div_pkg.sv | 34 +++
 rtl/div_step.sv | 32 +++
 rtl/div_unit.sv | 154 +++++++++++++++
 tb/tb_div_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg: shared types and constants for the iterative RV32M divider.
//   div_op_e     - funct3[1:0] encoding of DIV / DIVU / REM / REMU
//   div_state_e  - divider FSM state encoding
//   DIV_LATENCY / DIV_FAST_LATENCY - start-to-valid cycle counts
//   DIV_ZERO_Q / DIV_OVF_Q          - architected special-case quotients
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_CALC = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

    localparam int          DIV_LATENCY      = 34;
    localparam int          DIV_FAST_LATENCY = 2;
    localparam logic [31:0] DIV_ZERO_Q       = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_Q        = 32'h8000_0000;

    // Magnitude of v when treated as signed; pass-through for unsigned ops.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step: one combinational radix-2 restoring division iteration.
//   rem_i  [XLEN:0]   partial remainder before the step
//   quo_i  [XLEN-1:0] quotient / remaining-dividend shift register
//   dvs_i  [XLEN-1:0] divisor magnitude
//   rem_o  [XLEN:0]   partial remainder after the step
//   quo_o  [XLEN-1:0] shift register after the step (new quotient bit in [0])
// ---------------------------------------------------------------------------
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    // One extra bit above the shifted remainder makes the trial result's MSB
    // a clean sign bit even for a full-width unsigned divisor.
    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;
    logic            keep;

    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign trial   = shifted - {2'b00, dvs_i};
    assign keep    = ~trial[XLEN+1];

    assign rem_o = keep ? trial[XLEN:0] : shifted[XLEN:0];
    assign quo_o = {quo_i[XLEN-2:0], keep};

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit: iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU.
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   start_i      request, accepted only in IDLE
//   kill_i       flush; aborts any operation, wins over start_i
//   div_op_i     funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   operand_a_i  dividend
//   operand_b_i  divisor
//   busy_o       high whenever the FSM is not in IDLE
//   valid_o      one-cycle result pulse (the DONE cycle)
//   result_o     quotient or remainder, held until the next DONE
// Flow: IDLE -> PREP -> CALC x32 -> DONE -> IDLE; divide-by-zero and signed
// overflow skip CALC and go PREP -> DONE. All outputs are registered.
// ---------------------------------------------------------------------------
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [1:0]      div_op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] PREP = ST_PREP;
    localparam logic [1:0] CALC = ST_CALC;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]      state_q;
    logic [4:0]      cnt_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic            neg_q;
    logic            neg_r;

    // op_q[0] clear = signed op, op_q[1] set = remainder wanted
    logic            is_signed;
    logic            want_rem;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            ovf;

    assign is_signed = ~op_q[0];
    assign want_rem  = op_q[1];
    assign a_mag     = mag(a_q, is_signed);
    assign b_mag     = mag(b_q, is_signed);
    assign div_zero  = (b_q == '0);
    assign ovf       = is_signed && (a_q == DIV_OVF_Q) && (b_q == '1);

    logic [XLEN:0]   rem_n;
    logic [XLEN-1:0] quo_n;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_n),
        .quo_o (quo_n)
    );

    // Sign fix-up applied to the final iteration's outputs so the result can
    // be registered on the edge entering DONE.
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;

    assign q_fin = neg_q ? ('0 - quo_n) : quo_n;
    assign r_fin = neg_r ? ('0 - rem_n[XLEN-1:0]) : rem_n[XLEN-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            valid_o <= 1'b0;
            if (kill_i) begin
                state_q <= IDLE;
                busy_o  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            state_q <= PREP;
                            busy_o  <= 1'b1;
                            op_q    <= div_op_i;
                            a_q     <= operand_a_i;
                            b_q     <= operand_b_i;
                        end
                    end
                    PREP: begin
                        neg_q <= is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
                        neg_r <= is_signed & a_q[XLEN-1];
                        if (div_zero) begin
                            // Architected results, no sign fix-up.
                            state_q  <= DONE;
                            valid_o  <= 1'b1;
                            result_o <= want_rem ? a_q : DIV_ZERO_Q;
                        end else if (ovf) begin
                            state_q  <= DONE;
                            valid_o  <= 1'b1;
                            result_o <= want_rem ? '0 : DIV_OVF_Q;
                        end else begin
                            state_q <= CALC;
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            dvs_q   <= b_mag;
                            cnt_q   <= 5'd31;
                        end
                    end
                    CALC: begin
                        rem_q <= rem_n;
                        quo_q <= quo_n;
                        cnt_q <= cnt_q - 5'd1;
                        if (cnt_q == 5'd0) begin
                            state_q  <= DONE;
                            valid_o  <= 1'b1;
                            result_o <= want_rem ? r_fin : q_fin;
                        end
                    end
                    default: begin
                        // DONE: start_i here is dropped, not queued.
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit: directed table plus corner sequences and a random sweep
// against a behavioural reference for div_unit.
// ---------------------------------------------------------------------------
module tb_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    always #5 clk = ~clk;

    div_unit #(.XLEN(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .kill_i      (kill),
        .div_op_i    (op),
        .operand_a_i (a),
        .operand_b_i (b),
        .busy_o      (busy),
        .valid_o     (valid),
        .result_o    (result)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        sx = x;
        sy = y;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return sx / sy;
            2'b01:   return x / y;
            2'b10:   return sx % sy;
            default: return x % y;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, follow it to valid, check latency/busy/result, then poke
    // start during DONE and confirm it is dropped.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] e, input int lat,
                          input bit meddle);
        int cyc;
        bit busy_bad;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        busy_bad = 1'b0;
        while (!valid && cyc < 60) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (meddle && cyc >= 4 && cyc <= 6) begin
                start = 1'b1; op = OP_REM; a = 32'd999; b = 32'd5;
            end else begin
                start = 1'b0; op = o; a = x; b = y;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check($sformatf("%s busy_low_early", name), {31'd0, busy_bad}, 32'd0);
        check($sformatf("%s valid", name), {31'd0, valid}, 32'd1);
        check($sformatf("%s latency", name), cyc, lat);
        check($sformatf("%s result", name), result, e);
        check($sformatf("%s busy_in_done", name), {31'd0, busy}, 32'd1);
        start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
        tick();
        start = 1'b0;
        check($sformatf("%s after_done busy/valid", name), {30'd0, busy, valid}, 32'd0);
        check($sformatf("%s result_hold", name), result, e);
    endtask

    initial begin
        logic [31:0] prev;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          saw_valid;
        int          rlat;

        vecs[0]  = '{OP_DIV,  32'd100,        32'd7,          32'h0000_000E, DIV_LATENCY};
        vecs[1]  = '{OP_REM,  32'd100,        32'd7,          32'h0000_0002, DIV_LATENCY};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, DIV_LATENCY};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, DIV_LATENCY};
        vecs[4]  = '{OP_DIVU, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC, DIV_LATENCY};
        vecs[5]  = '{OP_DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF, DIV_FAST_LATENCY};
        vecs[6]  = '{OP_REMU, 32'h1234_5678,  32'd0,          32'h1234_5678, DIV_FAST_LATENCY};
        vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, DIV_FAST_LATENCY};
        vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, DIV_FAST_LATENCY};
        vecs[9]  = '{OP_DIV,  32'd7,          32'd0,          32'hFFFF_FFFF, DIV_FAST_LATENCY};
        vecs[10] = '{OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, DIV_FAST_LATENCY};
        vecs[11] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, DIV_LATENCY};
        vecs[12] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, DIV_LATENCY};
        vecs[13] = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, DIV_LATENCY};
        vecs[14] = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE, DIV_LATENCY};
        vecs[15] = '{OP_REM,  32'd100,        32'hFFFF_FFF9,  32'h0000_0002, DIV_LATENCY};

        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) tick();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat, 1'b0);
        prev = vecs[15].exp;

        // Kill on the 10th CALC cycle, then restart one cycle later.
        op = OP_DIVU; a = 32'd1000; b = 32'd10; start = 1'b1;
        tick();
        start = 1'b0;
        saw_valid = 1'b0;
        repeat (10) begin
            tick();
            if (valid) saw_valid = 1'b1;
        end
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill busy", {31'd0, busy}, 32'd0);
        check("kill valid", {30'd0, valid, saw_valid}, 32'd0);
        check("kill result_hold", result, prev);
        run_op("kill_restart", OP_DIVU, 32'd1000, 32'd10, 32'd100, DIV_LATENCY, 1'b0);

        // Start during CALC with different operands must be ignored.
        run_op("start_ignored", OP_DIVU, 32'h0000_ABCD, 32'h10, 32'h0000_0ABC, DIV_LATENCY, 1'b1);

        // Reset in cycle k+20 abandons the op.
        op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset valid", {31'd0, valid}, 32'd0);
        check("midreset result", result, 32'd0);
        tick();
        run_op("after_reset", OP_REMU, 32'd1000, 32'd7, 32'd6, DIV_LATENCY, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            rlat = (rb == 32'd0 || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))
                   ? DIV_FAST_LATENCY : DIV_LATENCY;
            run_op($sformatf("rnd%0d op%0d %h/%h", n, ro, ra, rb), ro, ra, rb,
                   ref_div(ro, ra, rb), rlat, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
